// File: rtl/rasterizer_traversal.sv
// Triangle traversal backend: clips the setup bounding box to the framebuffer, then walks it
// one pixel per cycle with incremental edge/depth stepping behind a valid/ready output register.
module rasterizer_traversal #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 16,
    parameter int ADDR_WIDTH  = 15,
    parameter int FB_WIDTH    = 160,
    parameter int FB_HEIGHT   = 120,
    parameter int EMIT_ALL    = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       tri_valid,
    output logic                       tri_ready,
    input  logic [1:0][DATA_WIDTH-1:0] bb_tl,      // [1]=x, [0]=y
    input  logic [1:0][DATA_WIDTH-1:0] bb_br,
    input  logic [2:0][DATA_WIDTH-1:0] edge_init,  // edge values at bb_tl; "edge" is a reserved word
    input  logic [2:0][DATA_WIDTH-1:0] edge_dx,
    input  logic [2:0][DATA_WIDTH-1:0] edge_dy,
    input  logic [DATA_WIDTH-1:0]      z,
    input  logic [DATA_WIDTH-1:0]      z_dx,
    input  logic [DATA_WIDTH-1:0]      z_dy,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic [ADDR_WIDTH-1:0]      pix_addr,
    output logic [DEPTH_WIDTH-1:0]     pix_depth,
    output logic                       pix_inside,
    output logic                       done
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;

    typedef logic signed [DW-1:0]   sd_t;
    typedef logic signed [2*DW-1:0] sw_t;
    typedef logic [2:0][DW-1:0]     e3_t;
    typedef logic [AW-1:0]          addr_t;
    typedef enum logic [1:0] {IDLE, SETUP, TRAVERSE, DONE} state_t;

    localparam sd_t X_LAST = sd_t'(FB_WIDTH - 1);
    localparam sd_t Y_LAST = sd_t'(FB_HEIGHT - 1);

    function automatic sw_t sext(input logic [DW-1:0] v);
        return {{DW{v[DW-1]}}, v};
    endfunction

    state_t state_q, state_d;
    sd_t    tlx_q, tlx_d, tly_q, tly_d, brx_q, brx_d, bry_q, bry_d;
    e3_t    edx_q, edx_d, edy_q, edy_d;
    sd_t    zdx_q, zdx_d, zdy_q, zdy_d;
    sd_t    x_q, x_d, y_q, y_d, xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
    e3_t    e_q, e_d, row_e_q, row_e_d;
    sd_t    z_q, z_d, row_z_q, row_z_d;
    addr_t  addr_q, addr_d, jump_q, jump_d;
    logic   last_q, last_d;
    logic   pix_valid_q, pix_valid_d, pix_inside_q, pix_inside_d, done_q, done_d;
    addr_t  pix_addr_q, pix_addr_d;
    logic [DEPTH_WIDTH-1:0] pix_depth_q, pix_depth_d;

    // Box clipping and start-point adjustment, evaluated from the captured setup
    sd_t   xmin_s, ymin_s, xmax_s, ymax_s, z_adj;
    sw_t   offx, offy;
    e3_t   e_adj;
    addr_t addr_s, jump_s;
    logic  empty_s;

    always_comb begin
        xmin_s  = (tlx_q < 0) ? '0 : tlx_q;
        ymin_s  = (tly_q < 0) ? '0 : tly_q;
        xmax_s  = (brx_q > X_LAST) ? X_LAST : brx_q;
        ymax_s  = (bry_q > Y_LAST) ? Y_LAST : bry_q;
        offx    = sext(xmin_s) - sext(tlx_q);
        offy    = sext(ymin_s) - sext(tly_q);
        for (int i = 0; i < 3; i++)
            e_adj[i] = e_q[i] + sd_t'(sext(edx_q[i]) * offx) + sd_t'(sext(edy_q[i]) * offy);
        z_adj   = z_q + sd_t'(sext(zdx_q) * offx) + sd_t'(sext(zdy_q) * offy);
        addr_s  = addr_t'(sext(ymin_s) * sw_t'(FB_WIDTH) + sext(xmin_s));
        jump_s  = addr_t'(FB_WIDTH) - addr_t'(xmax_s - xmin_s);
        empty_s = (xmin_s > xmax_s) || (ymin_s > ymax_s);
    end

    // Candidate pixel: straight from setup in SETUP, otherwise the cursor registers
    sd_t   cx, cy, cxmin, cxmax, cymax, cz, crow_z, nx, ny, nz, nrow_z;
    e3_t   ce, crow_e, ne, nrow_e;
    addr_t caddr, cjump, naddr;
    logic  c_inside, nlast;

    always_comb begin
        if (state_q == SETUP) begin
            cx = xmin_s; cy = ymin_s; cxmin = xmin_s; cxmax = xmax_s; cymax = ymax_s;
            ce = e_adj; crow_e = e_adj; cz = z_adj; crow_z = z_adj;
            caddr = addr_s; cjump = jump_s;
        end else begin
            cx = x_q; cy = y_q; cxmin = xmin_q; cxmax = xmax_q; cymax = ymax_q;
            ce = e_q; crow_e = row_e_q; cz = z_q; crow_z = row_z_q;
            caddr = addr_q; cjump = jump_q;
        end
        c_inside = 1'b1;
        for (int i = 0; i < 3; i++)
            c_inside = c_inside && ($signed(ce[i]) > 0);

        nx = cx; ny = cy; ne = ce; nz = cz; naddr = caddr;
        nrow_e = crow_e; nrow_z = crow_z; nlast = 1'b0;
        if (cx < cxmax) begin
            nx = cx + sd_t'(1);
            for (int i = 0; i < 3; i++) ne[i] = ce[i] + edx_q[i];
            nz    = cz + zdx_q;
            naddr = caddr + addr_t'(1);
        end else if (cy < cymax) begin
            nx = cxmin;
            ny = cy + sd_t'(1);
            for (int i = 0; i < 3; i++) nrow_e[i] = crow_e[i] + edy_q[i];
            nrow_z = crow_z + zdy_q;
            ne     = nrow_e;
            nz     = nrow_z;
            naddr  = caddr + cjump;
        end else begin
            nlast = 1'b1;
        end
    end

    logic load;

    always_comb begin
        state_d = state_q;
        tlx_d = tlx_q; tly_d = tly_q; brx_d = brx_q; bry_d = bry_q;
        edx_d = edx_q; edy_d = edy_q; zdx_d = zdx_q; zdy_d = zdy_q;
        x_d = x_q; y_d = y_q; xmin_d = xmin_q; xmax_d = xmax_q; ymax_d = ymax_q;
        e_d = e_q; row_e_d = row_e_q; z_d = z_q; row_z_d = row_z_q;
        addr_d = addr_q; jump_d = jump_q; last_d = last_q;
        pix_valid_d = pix_valid_q; pix_addr_d = pix_addr_q;
        pix_depth_d = pix_depth_q; pix_inside_d = pix_inside_q;
        done_d = 1'b0;
        load   = 1'b0;
        case (state_q)
            IDLE: if (tri_valid) begin
                tlx_d = bb_tl[1]; tly_d = bb_tl[0]; brx_d = bb_br[1]; bry_d = bb_br[0];
                e_d = edge_init; edx_d = edge_dx; edy_d = edge_dy;
                z_d = z; zdx_d = z_dx; zdy_d = z_dy;
                last_d  = 1'b0;
                state_d = SETUP;
            end
            SETUP: begin
                xmin_d = xmin_s; xmax_d = xmax_s; ymax_d = ymax_s; jump_d = jump_s;
                if (empty_s) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    load    = 1'b1;
                    state_d = TRAVERSE;
                end
            end
            TRAVERSE: if (!pix_valid_q || pix_ready) begin
                if (last_q) begin
                    pix_valid_d = 1'b0;
                    state_d     = DONE;
                    done_d      = 1'b1;
                end else begin
                    load = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (load) begin
            pix_valid_d  = (EMIT_ALL != 0) || c_inside;
            pix_addr_d   = caddr;
            pix_depth_d  = cz[DEPTH_WIDTH-1:0];
            pix_inside_d = c_inside;
            x_d = nx; y_d = ny; e_d = ne; z_d = nz; addr_d = naddr;
            row_e_d = nrow_e; row_z_d = nrow_z; last_d = nlast;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            tlx_q <= '0; tly_q <= '0; brx_q <= '0; bry_q <= '0;
            edx_q <= '0; edy_q <= '0; zdx_q <= '0; zdy_q <= '0;
            x_q <= '0; y_q <= '0; xmin_q <= '0; xmax_q <= '0; ymax_q <= '0;
            e_q <= '0; row_e_q <= '0; z_q <= '0; row_z_q <= '0;
            addr_q <= '0; jump_q <= '0; last_q <= 1'b0;
            pix_valid_q <= 1'b0; pix_addr_q <= '0; pix_depth_q <= '0;
            pix_inside_q <= 1'b0; done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tlx_q <= tlx_d; tly_q <= tly_d; brx_q <= brx_d; bry_q <= bry_d;
            edx_q <= edx_d; edy_q <= edy_d; zdx_q <= zdx_d; zdy_q <= zdy_d;
            x_q <= x_d; y_q <= y_d; xmin_q <= xmin_d; xmax_q <= xmax_d; ymax_q <= ymax_d;
            e_q <= e_d; row_e_q <= row_e_d; z_q <= z_d; row_z_q <= row_z_d;
            addr_q <= addr_d; jump_q <= jump_d; last_q <= last_d;
            pix_valid_q <= pix_valid_d; pix_addr_q <= pix_addr_d; pix_depth_q <= pix_depth_d;
            pix_inside_q <= pix_inside_d; done_q <= done_d;
        end
    end

    assign tri_ready  = (state_q == IDLE);
    assign pix_valid  = pix_valid_q;
    assign pix_addr   = pix_addr_q;
    assign pix_depth  = pix_depth_q;
    assign pix_inside = pix_inside_q;
    assign done       = done_q;

endmodule

// File: tb/tb_rasterizer_traversal.sv
// Directed bench for rasterizer_traversal: a vector table of triangles with hand-computed pixel
// streams, plus sequences for backpressure, off-screen timing, EMIT_ALL and mid-traversal reset.
module tb_rasterizer_traversal;
    typedef struct packed {
        int tlx, tly, brx, bry;
        logic [2:0][15:0] e, edx, edy;
        int zz, zdx, zdy;
        int npix;
        logic [3:0][15:0] addr, depth;
        logic [3:0] ins;
    } vec_t;

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] depth;
        logic        ins;
    } pix_t;

    logic clk = 1'b0, rstn = 1'b0, tri_valid0 = 1'b0, tri_valid1 = 1'b0, pix_ready = 1'b1;
    logic [1:0][15:0] bb_tl = '0, bb_br = '0;
    logic [2:0][15:0] edge_init = '0, edge_dx = '0, edge_dy = '0;
    logic [15:0] z = '0, z_dx = '0, z_dy = '0;
    logic tri_ready0, tri_ready1, pix_valid0, pix_valid1, pix_inside0, pix_inside1, done0, done1;
    logic [14:0] pix_addr0, pix_addr1;
    logic [15:0] pix_depth0, pix_depth1;

    always #5 clk = ~clk;

    rasterizer_traversal #(.EMIT_ALL(0)) dut0 (
        .clk(clk), .rstn(rstn), .tri_valid(tri_valid0), .tri_ready(tri_ready0),
        .bb_tl(bb_tl), .bb_br(bb_br), .edge_init(edge_init), .edge_dx(edge_dx), .edge_dy(edge_dy),
        .z(z), .z_dx(z_dx), .z_dy(z_dy), .pix_valid(pix_valid0), .pix_ready(pix_ready),
        .pix_addr(pix_addr0), .pix_depth(pix_depth0), .pix_inside(pix_inside0), .done(done0));

    rasterizer_traversal #(.EMIT_ALL(1)) dut1 (
        .clk(clk), .rstn(rstn), .tri_valid(tri_valid1), .tri_ready(tri_ready1),
        .bb_tl(bb_tl), .bb_br(bb_br), .edge_init(edge_init), .edge_dx(edge_dx), .edge_dy(edge_dy),
        .z(z), .z_dx(z_dx), .z_dy(z_dy), .pix_valid(pix_valid1), .pix_ready(pix_ready),
        .pix_addr(pix_addr1), .pix_depth(pix_depth1), .pix_inside(pix_inside1), .done(done1));

    pix_t q0[$];
    pix_t q1[$];

    always @(negedge clk) begin
        if (rstn && pix_valid0 && pix_ready) q0.push_back({pix_addr0, pix_depth0, pix_inside0});
        if (rstn && pix_valid1 && pix_ready) q1.push_back({pix_addr1, pix_depth1, pix_inside1});
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int tlx, tly, brx, bry, e0, e1, e2,
                                input int dx0, dx1, dx2, dy0, dy1, dy2, zz, zdx, zdy);
        vec_t v;
        v = '0;
        v.tlx = tlx; v.tly = tly; v.brx = brx; v.bry = bry;
        v.e[0] = e0[15:0];   v.e[1] = e1[15:0];   v.e[2] = e2[15:0];
        v.edx[0] = dx0[15:0]; v.edx[1] = dx1[15:0]; v.edx[2] = dx2[15:0];
        v.edy[0] = dy0[15:0]; v.edy[1] = dy1[15:0]; v.edy[2] = dy2[15:0];
        v.zz = zz; v.zdx = zdx; v.zdy = zdy;
        return v;
    endfunction

    function automatic vec_t addp(input vec_t v, input int a, input int d, input bit ins);
        v.addr[v.npix[1:0]]  = a[15:0];
        v.depth[v.npix[1:0]] = d[15:0];
        v.ins[v.npix[1:0]]   = ins;
        v.npix = v.npix + 1;
        return v;
    endfunction

    task automatic handshake(input vec_t v, input bit sel);
        int k;
        k = 0;
        while (!(sel ? tri_ready1 : tri_ready0) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("tri_ready before send", sel ? tri_ready1 : tri_ready0, 1);
        bb_tl[1] = v.tlx[15:0]; bb_tl[0] = v.tly[15:0];
        bb_br[1] = v.brx[15:0]; bb_br[0] = v.bry[15:0];
        edge_init = v.e; edge_dx = v.edx; edge_dy = v.edy;
        z = v.zz[15:0]; z_dx = v.zdx[15:0]; z_dy = v.zdy[15:0];
        if (sel) tri_valid1 = 1'b1; else tri_valid0 = 1'b1;
        @(posedge clk); #1;
        tri_valid0 = 1'b0;
        tri_valid1 = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int k;
        k = 0;
        while (!(sel ? done1 : done0) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done pulse seen", sel ? done1 : done0, 1);
    endtask

    task automatic check_pix(input string nm, input pix_t q[$], input vec_t v);
        chk({nm, " pixel count"}, q.size(), v.npix);
        for (int j = 0; j < v.npix && j < q.size(); j++) begin
            chk($sformatf("%s px%0d addr", nm, j), q[j].addr, v.addr[j]);
            chk($sformatf("%s px%0d depth", nm, j), q[j].depth, v.depth[j]);
            chk($sformatf("%s px%0d inside", nm, j), q[j].ins, v.ins[j]);
        end
    endtask

    initial begin
        vec_t vecs[6];
        vec_t v;
        int k;

        // full inside 2x2
        vecs[0] = mk(0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        vecs[0] = addp(vecs[0], 0, 5, 1);   vecs[0] = addp(vecs[0], 1, 5, 1);
        vecs[0] = addp(vecs[0], 160, 5, 1); vecs[0] = addp(vecs[0], 161, 5, 1);
        // left clip: e0 and z advanced by two x steps
        vecs[1] = mk(-2, 5, 1, 5, 0, 10, 10, 1, 0, 0, 0, 0, 0, 7, 3, 0);
        vecs[1] = addp(vecs[1], 800, 13, 1); vecs[1] = addp(vecs[1], 801, 16, 1);
        // e0 goes 2,1,0,-1: only the first two are inside
        vecs[2] = mk(0, 0, 3, 0, 2, 10, 10, -1, 0, 0, 0, 0, 0, 100, -1, 0);
        vecs[2] = addp(vecs[2], 0, 100, 1); vecs[2] = addp(vecs[2], 1, 99, 1);
        // bottom/right clip with row stepping
        vecs[3] = mk(158, 118, 165, 130, 5, 1, 1, 0, 0, 0, -2, 0, 0, 1000, 0, 10);
        vecs[3] = addp(vecs[3], 19038, 1000, 1); vecs[3] = addp(vecs[3], 19039, 1000, 1);
        vecs[3] = addp(vecs[3], 19198, 1010, 1); vecs[3] = addp(vecs[3], 19199, 1010, 1);
        // top clip to a single pixel
        vecs[4] = mk(3, -2, 3, 0, -1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 4);
        vecs[4] = addp(vecs[4], 3, 8, 1);
        // e0 == 0 everywhere: zero is outside, nothing emitted
        vecs[5] = mk(0, 0, 1, 0, 0, 5, 5, 0, 0, 0, 0, 0, 0, 9, 0, 0);

        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset pix_valid", pix_valid0, 0);
        chk("reset done", done0, 0);
        chk("reset tri_ready", tri_ready0, 1);
        chk("reset pix_addr", pix_addr0, 0);
        chk("reset pix_valid emit_all", pix_valid1, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            q0.delete();
            handshake(vecs[i], 1'b0);
            wait_done(1'b0);
            @(posedge clk); #1;
            check_pix($sformatf("vec%0d", i), q0, vecs[i]);
        end

        // backpressure on the second pixel
        q0.delete();
        handshake(vecs[0], 1'b0);
        chk("bp setup no valid", pix_valid0, 0);
        @(posedge clk); #1;
        chk("bp first pixel latency", pix_valid0, 1);
        chk("bp first addr", pix_addr0, 0);
        @(posedge clk); #1;
        chk("bp addr1 present", pix_addr0, 1);
        pix_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp hold valid", pix_valid0, 1);
            chk("bp hold addr", pix_addr0, 1);
            chk("bp hold depth", pix_depth0, 5);
        end
        pix_ready = 1'b1;
        wait_done(1'b0);
        @(posedge clk); #1;
        check_pix("bp", q0, vecs[0]);

        // fully off-screen: done at T+2, ready at T+3
        q0.delete();
        v = mk(170, 0, 180, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        handshake(v, 1'b0);
        chk("offscr T+1 done", done0, 0);
        chk("offscr T+1 tri_ready", tri_ready0, 0);
        @(posedge clk); #1;
        chk("offscr T+2 done", done0, 1);
        chk("offscr T+2 pix_valid", pix_valid0, 0);
        @(posedge clk); #1;
        chk("offscr T+3 tri_ready", tri_ready0, 1);
        chk("offscr T+3 done", done0, 0);
        chk("offscr pixel count", q0.size(), 0);

        // EMIT_ALL instance emits every pixel with its inside flag
        q1.delete();
        v = vecs[2];
        v.npix = 0;
        v = addp(v, 0, 100, 1); v = addp(v, 1, 99, 1);
        v = addp(v, 2, 98, 0);  v = addp(v, 3, 97, 0);
        handshake(v, 1'b1);
        wait_done(1'b1);
        @(posedge clk); #1;
        check_pix("emit_all", q1, v);

        // reset during the third pixel of a 10x10 box
        q0.delete();
        v = mk(0, 0, 9, 9, 1, 1, 1, 0, 0, 0, 0, 0, 0, 33, 0, 0);
        handshake(v, 1'b0);
        k = 0;
        while (!(pix_valid0 && pix_addr0 == 15'd2) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rst third pixel reached", pix_addr0, 2);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("rst pix_valid", pix_valid0, 0);
        chk("rst done", done0, 0);
        chk("rst pix_addr", pix_addr0, 0);
        chk("rst pix_depth", pix_depth0, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst tri_ready after release", tri_ready0, 1);
        chk("rst no done pulse", done0, 0);
        q0.delete();
        handshake(vecs[0], 1'b0);
        wait_done(1'b0);
        @(posedge clk); #1;
        check_pix("post_rst", q0, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
